// File: rtl/booth_mult_pkg.sv
// Shared types and helpers for the radix-4 Booth multiplier.
package booth_mult_pkg;

   // Sequencer states
   typedef enum logic [1:0] {
      IDLE,
      CALC,
      DONE
   } state_t;

   // Radix-4 Booth digit selected from a 3-bit multiplier window
   typedef enum logic [2:0] {
      ZERO,
      P1,
      M1,
      P2,
      M2
   } booth_digit_t;

   // Radix-4 iterations needed to cover an operand extended by two bits
   function automatic int unsigned n_iter(input int unsigned l_word);
      return l_word / 2 + 1;
   endfunction

endpackage

// File: rtl/booth_r4_enc.sv
// Combinational radix-4 Booth recoder: {m[2i+1], m[2i], m[2i-1]} -> digit.
module booth_r4_enc
   import booth_mult_pkg::*;
(
   input  logic [2:0]   win,
   output booth_digit_t digit_c
);

   // Standard modified-Booth window decode
   always_comb begin
      digit_c = ZERO;
      unique case (win)
         3'b000:  digit_c = ZERO;
         3'b001:  digit_c = P1;
         3'b010:  digit_c = P1;
         3'b011:  digit_c = P2;
         3'b100:  digit_c = M2;
         3'b101:  digit_c = M1;
         3'b110:  digit_c = M1;
         3'b111:  digit_c = ZERO;
         default: digit_c = ZERO;
      endcase
   end

endmodule

// File: rtl/booth_mult_radix4.sv
// Sequential radix-4 Booth multiplier, two multiplier bits per cycle,
// signed or unsigned operands under a start/ready handshake.
module booth_mult_radix4
   import booth_mult_pkg::*;
#(
   parameter int unsigned L_WORD = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic                  signed_mode,
   input  logic [L_WORD-1:0]     word1,
   input  logic [L_WORD-1:0]     word2,
   output logic [2*L_WORD-1:0]   product,
   output logic                  ready,
   output logic                  busy,
   output logic                  err
);

   localparam int unsigned N_ITER = n_iter(L_WORD);
   localparam int unsigned EXT_W  = L_WORD + 2;
   localparam int unsigned ACC_W  = 2 * L_WORD + 4;
   localparam int unsigned CNT_W  = $clog2(N_ITER + 1);

   state_t             state;
   logic [CNT_W-1:0]   cnt;
   logic [EXT_W-1:0]   mcand;
   logic [EXT_W-1:0]   mplr;
   logic               m_prev;
   logic [ACC_W-1:0]   acc;

   booth_digit_t       digit_c;
   logic [ACC_W-1:0]   mcand_acc;
   logic [ACC_W-1:0]   multiple;
   logic [ACC_W-1:0]   addend;

   // Sign or zero extension makes unsigned operands positive for the signed recoder
   function automatic logic [EXT_W-1:0] extend(input logic [L_WORD-1:0] w, input logic s);
      return {{2{s & w[L_WORD-1]}}, w};
   endfunction

   booth_r4_enc u_enc (
      .win     ({mplr[1:0], m_prev}),
      .digit_c (digit_c)
   );

   // Digit x multiplicand, aligned at bit 2*cnt, in full accumulator width
   always_comb begin
      mcand_acc = {{(ACC_W - EXT_W){mcand[EXT_W-1]}}, mcand};
      multiple  = '0;
      unique case (digit_c)
         ZERO:    multiple = '0;
         P1:      multiple = mcand_acc;
         M1:      multiple = -mcand_acc;
         P2:      multiple = mcand_acc << 1;
         M2:      multiple = -(mcand_acc << 1);
         default: multiple = '0;
      endcase
      addend = multiple << {cnt, 1'b0};
   end

   // Sequencer, operand registers, accumulator and registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         cnt     <= '0;
         mcand   <= '0;
         mplr    <= '0;
         m_prev  <= 1'b0;
         acc     <= '0;
         product <= '0;
         ready   <= 1'b0;
         busy    <= 1'b0;
         err     <= 1'b0;
      end else begin
         ready <= 1'b0;
         err   <= 1'b0;
         unique case (state)
            IDLE: begin
               if (start) begin
                  mcand  <= extend(word1, signed_mode);
                  mplr   <= extend(word2, signed_mode);
                  m_prev <= 1'b0;
                  acc    <= '0;
                  cnt    <= '0;
                  busy   <= 1'b1;
                  state  <= CALC;
               end
            end
            CALC: begin
               err    <= start;
               acc    <= acc + addend;
               mplr   <= {2'b00, mplr[EXT_W-1:2]};
               m_prev <= mplr[1];
               if (cnt == CNT_W'(N_ITER - 1)) begin
                  state <= DONE;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            DONE: begin
               err     <= start;
               product <= acc[2*L_WORD-1:0];
               ready   <= 1'b1;
               busy    <= 1'b0;
               state   <= IDLE;
            end
            default: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_booth_mult_radix4.sv
// Directed and model-checked bench for booth_mult_radix4 at L_WORD = 8, 4 and 16.
module tb_booth_mult_radix4;

   logic clk;
   logic rst_n;

   logic        start8, s8, ready8, busy8, err8;
   logic [7:0]  a8, b8;
   logic [15:0] product8;

   logic        start4, s4, ready4, busy4, err4;
   logic [3:0]  a4, b4;
   logic [7:0]  product4;

   logic        start16, s16, ready16, busy16, err16;
   logic [15:0] a16, b16;
   logic [31:0] product16;

   int n_tests;
   int n_fail;

   booth_mult_radix4 #(.L_WORD(8)) u_dut8 (
      .clk(clk), .rst_n(rst_n), .start(start8), .signed_mode(s8),
      .word1(a8), .word2(b8), .product(product8),
      .ready(ready8), .busy(busy8), .err(err8)
   );

   booth_mult_radix4 #(.L_WORD(4)) u_dut4 (
      .clk(clk), .rst_n(rst_n), .start(start4), .signed_mode(s4),
      .word1(a4), .word2(b4), .product(product4),
      .ready(ready4), .busy(busy4), .err(err4)
   );

   booth_mult_radix4 #(.L_WORD(16)) u_dut16 (
      .clk(clk), .rst_n(rst_n), .start(start16), .signed_mode(s16),
      .word1(a16), .word2(b16), .product(product16),
      .ready(ready16), .busy(busy16), .err(err16)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   // One 8-bit operation with exact handshake timing checks
   task automatic mul8(input string tag, input logic s, input logic [7:0] a,
                       input logic [7:0] b, input logic [15:0] e);
      int busy_cnt;
      int early;
      @(negedge clk);
      s8 = s; a8 = a; b8 = b; start8 = 1'b1;
      @(posedge clk);
      #1 start8 = 1'b0;
      busy_cnt = busy8 ? 1 : 0;
      early    = 0;
      for (int k = 1; k < 6; k++) begin
         @(posedge clk);
         #1;
         if (busy8) busy_cnt++;
         if (ready8) early++;
      end
      check({tag, "_busy_cycles"}, 64'(busy_cnt), 64'd6);
      check({tag, "_early_ready"}, 64'(early), 64'd0);
      @(posedge clk);
      #1;
      check({tag, "_ready"}, 64'(ready8), 64'd1);
      check({tag, "_product"}, 64'(product8), 64'(e));
      @(posedge clk);
      #1;
      check({tag, "_ready_drop"}, 64'(ready8), 64'd0);
      check({tag, "_busy_drop"}, 64'(busy8), 64'd0);
      check({tag, "_hold"}, 64'(product8), 64'(e));
   endtask

   task automatic mul4(input logic s, input logic [3:0] a, input logic [3:0] b);
      logic [7:0] e;
      int n;
      if (s) e = $signed(a) * $signed(b);
      else   e = a * b;
      @(negedge clk);
      s4 = s; a4 = a; b4 = b; start4 = 1'b1;
      @(posedge clk);
      #1 start4 = 1'b0;
      n = 0;
      while (!ready4 && n < 20) begin
         @(posedge clk);
         #1;
         n++;
      end
      check("l4_ready", 64'(ready4), 64'd1);
      check(s ? "l4_signed" : "l4_unsigned", 64'(product4), 64'(e));
   endtask

   task automatic mul16(input logic s, input logic [15:0] a, input logic [15:0] b);
      logic [31:0] e;
      int n;
      if (s) e = $signed(a) * $signed(b);
      else   e = a * b;
      @(negedge clk);
      s16 = s; a16 = a; b16 = b; start16 = 1'b1;
      @(posedge clk);
      #1 start16 = 1'b0;
      n = 0;
      while (!ready16 && n < 30) begin
         @(posedge clk);
         #1;
         n++;
      end
      check("l16_latency", 64'(n), 64'd10);
      check(s ? "l16_signed" : "l16_unsigned", 64'(product16), 64'(e));
   endtask

   initial begin
      int n;
      n_tests = 0;
      n_fail  = 0;
      rst_n   = 1'b0;
      start8  = 1'b0; s8  = 1'b0; a8  = '0; b8  = '0;
      start4  = 1'b0; s4  = 1'b0; a4  = '0; b4  = '0;
      start16 = 1'b0; s16 = 1'b0; a16 = '0; b16 = '0;
      #1;
      check("rst_product", 64'(product8), 64'd0);
      check("rst_ready", 64'(ready8), 64'd0);
      check("rst_busy", 64'(busy8), 64'd0);
      check("rst_err", 64'(err8), 64'd0);
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      // Directed 8-bit vectors
      mul8("s_m128sq", 1'b1, 8'h80, 8'h80, 16'h4000);
      mul8("u_255sq",  1'b0, 8'hFF, 8'hFF, 16'hFE01);
      mul8("s_m1sq",   1'b1, 8'hFF, 8'hFF, 16'h0001);
      mul8("s_m1x127", 1'b1, 8'hFF, 8'h7F, 16'hFF81);
      mul8("u_128x2",  1'b0, 8'h80, 8'h02, 16'h0100);

      // Restart during CALC: err pulse, original result unaffected
      @(negedge clk);
      s8 = 1'b0; a8 = 8'd3; b8 = 8'd5; start8 = 1'b1;
      @(posedge clk);
      #1 start8 = 1'b0;
      @(posedge clk);
      #1;
      check("err_quiet", 64'(err8), 64'd0);
      @(negedge clk);
      s8 = 1'b1; a8 = 8'd10; b8 = 8'd10; start8 = 1'b1;
      @(posedge clk);
      #1 start8 = 1'b0;
      check("err_pulse", 64'(err8), 64'd1);
      @(posedge clk);
      #1;
      check("err_one_cycle", 64'(err8), 64'd0);
      repeat (2) @(posedge clk);
      #1;
      check("err_ready_not_early", 64'(ready8), 64'd0);
      @(posedge clk);
      #1;
      check("err_ready_on_time", 64'(ready8), 64'd1);
      check("err_first_product", 64'(product8), 64'h000F);
      n = 0;
      repeat (10) begin
         @(posedge clk);
         #1;
         if (ready8) n++;
      end
      check("err_no_second_ready", 64'(n), 64'd0);

      // Reset in the third CALC cycle aborts the operation
      @(negedge clk);
      s8 = 1'b0; a8 = 8'd200; b8 = 8'd200; start8 = 1'b1;
      @(posedge clk);
      #1 start8 = 1'b0;
      repeat (2) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("abort_product", 64'(product8), 64'd0);
      check("abort_ready", 64'(ready8), 64'd0);
      check("abort_busy", 64'(busy8), 64'd0);
      check("abort_err", 64'(err8), 64'd0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      n = 0;
      repeat (10) begin
         @(posedge clk);
         #1;
         if (ready8) n++;
      end
      check("abort_no_ready", 64'(n), 64'd0);
      mul8("u_7x9", 1'b0, 8'd7, 8'd9, 16'h003F);

      // Exhaustive 4-bit in both modes
      for (int m = 0; m < 2; m++)
         for (int i = 0; i < 16; i++)
            for (int j = 0; j < 16; j++)
               mul4(1'(m), 4'(i), 4'(j));

      // 16-bit corners and random vectors
      mul16(1'b1, 16'h8000, 16'h8000);
      mul16(1'b0, 16'hFFFF, 16'hFFFF);
      mul16(1'b1, 16'h7FFF, 16'h8000);
      for (int k = 0; k < 40; k++) begin
         mul16(1'b1, 16'($urandom), 16'($urandom));
         mul16(1'b0, 16'($urandom), 16'($urandom));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/booth_mult_radix4.md
# booth_mult_radix4

Parametrised sequential radix-4 (modified) Booth multiplier. It succeeds the fixed 4-bit radix-2 unit. It takes two L_WORD-bit operands under a start/ready handshake in either two's-complement or unsigned mode, and retires two multiplier bits per cycle. It sits in the arithmetic library next to the radix-2 multiplier as a drop-in for datapaths that need wider words, mixed signedness or lower latency.

## Interface
- L_WORD, 8, operand width; even, ≥4
- N_ITER, L_WORD/2+1, derived localparam (not overridable); number of radix-4 iterations
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  request; sampled on a rising edge, accepted only in IDLE
- signed_mode  in  1  1 = both operands two's complement, 0 = both unsigned; latched with operands
- word1  in  L_WORD  multiplicand
- word2  in  L_WORD  multiplier
- product  out  2*L_WORD  result; registered; holds until the next accepted start
- ready  out  1  one-cycle pulse; product is valid from this cycle onward
- busy  out  1  high in CALC and DONE
- err  out  1  one-cycle pulse when start is sampled outside IDLE; that request is dropped

## Operation
- Reset values: product=0, ready=0, busy=0, err=0, state=IDLE, internal registers 0. Reset asserted mid-operation aborts at once; no ready follows.
- FSM has three states:
  - IDLE: start=1 → latch operands, go to CALC.
  - CALC: run N_ITER cycles, then go to DONE.
  - DONE: one cycle, then back to IDLE.
- Operand extension at accept: both operands are extended to L_WORD+2 bits. Use sign extension when signed_mode=1 and zero extension when signed_mode=0. This lets unsigned values use the same signed recoder.
- Each CALC cycle:
  - Recode the 3-bit window {m[2i+1], m[2i], m[2i-1]} (m[-1]=0) into a digit in {0,+1,−1,+2,−2}.
  - Add digit×multiplicand into an accumulator of width 2*L_WORD+4, aligned at bit 2i.
  - Arithmetic is two's complement at full accumulator width, so intermediate values never overflow.
- In DONE: product ← accumulator[2*L_WORD-1:0] and ready=1. The result always fits, e.g. unsigned (2^L−1)^2 and signed (−2^(L−1))^2.
- Start during CALC or DONE → err=1 for the next cycle. The running operation, product, and the ready timing are all unaffected.
- Changes to signed_mode, word1 or word2 after accept have no effect.

## Timing
- Start sampled at edge E0 → busy=1 after E0.
- ready=1 and the new product are visible after edge E0+N_ITER+1. For L_WORD=8 that is E6.
- After edge E0+N_ITER+2: ready=0, busy=0, and the unit is back in IDLE.
- The earliest next accept is edge E0+N_ITER+2, giving a throughput of one result per N_ITER+2 cycles.
- err is registered: start sampled outside IDLE at edge Ek → err=1 during the cycle after Ek only.
- Sustained start=1: accepts at E0, raises err for every edge in CALC and DONE, then accepts again at E0+N_ITER+2.

## Structure
- Package booth_mult_pkg holds three items:
  - the state enum typedef {IDLE, CALC, DONE};
  - the Booth digit enum typedef {ZERO, P1, M1, P2, M2};
  - a function n_iter(l_word) returning l_word/2+1.
- Sub-module booth_r4_enc: a combinational 3-bit window → Booth digit recoder, instantiated once.
- Top level holds the FSM, iteration counter, multiplier shift register and accumulator adder.

## Test plan
- L_WORD=8, signed, −128 × −128 → product=16'h4000, ready exactly 6 cycles after the start edge, busy high for 6 cycles.
- L_WORD=8, unsigned, 255 × 255 → product=16'hFE01. In signed mode the same bits (−1 × −1) → 16'h0001.
- L_WORD=8, signed, 8'hFF × 8'h7F → 16'hFF81 (−127). Unsigned 8'h80 × 8'h02 → 16'h0100.
- Start re-pulsed 2 cycles after accept, with different operands → err=1 for one cycle. The first result, 3 × 5 = 16'h000F, still arrives on time and no second ready is produced.
- rst_n low in the 3rd CALC cycle → all outputs 0 immediately and no ready. After release, unsigned 7 × 9 → 16'h003F.
- L_WORD=4, exhaustive 16×16 operands in both modes, compared against a behavioural $signed/$unsigned model. This covers the 16 × 16 = 256 cases per mode. Also L_WORD=16 with random vectors.
